// File: rtl/jk_cmd_seq_if.sv
// rtl/jk_cmd_seq_if.sv - command handshake bundle for the jkff command sequencer
interface jk_cmd_seq_if #(
    parameter int LEN_W = 8
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [LEN_W-1:0] cmd_len;

    modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);
endinterface

// File: rtl/jk_cmd_seq.sv
// rtl/jk_cmd_seq.sv - queued j/k command player with a flip-flop reference check
module jk_cmd_seq #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    jk_cmd_seq_if.slave cmd,
    input  logic        q,
    output logic        j,
    output logic        k,
    output logic        exp_q,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

    state_t           state, state_nx;
    logic [1:0]       mem_op  [DEPTH];
    logic [LEN_W-1:0] mem_len [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [1:0]       op;
    logic [LEN_W-1:0] cnt;
    logic             exp_known;
    logic             full, push, pop;
    logic             j_nx, k_nx, done_nx;

    assign full          = (count == (AW+1)'(DEPTH));
    assign cmd.cmd_ready = !full;
    assign push          = cmd.cmd_valid && !full;
    assign busy          = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // j/k/done are registered from the next state so they line up with DRIVE/CHECK
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        j_nx     = 1'b0;
        k_nx     = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop          = 1'b1;
                    state_nx     = DRIVE;
                    {j_nx, k_nx} = mem_op[rd_ptr];
                end
            end
            DRIVE: begin
                if (cnt == LEN_W'(1)) begin
                    state_nx = CHECK;
                    done_nx  = 1'b1;
                end else begin
                    {j_nx, k_nx} = op;
                end
            end
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            op        <= 2'b00;
            cnt       <= '0;
            j         <= 1'b0;
            k         <= 1'b0;
            done      <= 1'b0;
            exp_q     <= 1'b0;
            exp_known <= 1'b0;
            err       <= 1'b0;
        end else begin
            j    <= j_nx;
            k    <= k_nx;
            done <= done_nx;
            if (push) begin
                mem_op[wr_ptr]  <= cmd.cmd_op;
                mem_len[wr_ptr] <= cmd.cmd_len;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                op     <= mem_op[rd_ptr];
                cnt    <= (mem_len[rd_ptr] == '0) ? LEN_W'(1) : mem_len[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // reference flip-flop advances on the same edges the jkff samples j/k
            if (state == DRIVE) begin
                cnt <= cnt - 1'b1;
                case (op)
                    2'b01: begin exp_q <= 1'b0; exp_known <= 1'b1; end
                    2'b10: begin exp_q <= 1'b1; exp_known <= 1'b1; end
                    2'b11: exp_q <= ~exp_q;
                    default: ;
                endcase
            end
            if (state == CHECK && exp_known && (q != exp_q))
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb/tb_jk_cmd_seq.sv - randomized self-checking bench for jk_cmd_seq
module tb_jk_cmd_seq;
    localparam int DEPTH = 4;
    localparam int LEN_W = 8;
    localparam int MAXC  = 8192;
    localparam int BIG   = 1 << 30;

    logic clk = 1'b0;
    logic rst;
    logic q, j, k, exp_q, busy, done, err;
    bit   tb_ff = 1'b1;
    bit   stub;

    jk_cmd_seq_if #(.LEN_W(LEN_W)) cmd_bus ();

    jk_cmd_seq #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cmd(cmd_bus.slave), .q(q),
        .j(j), .k(k), .exp_q(exp_q), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        case ({j, k})
            2'b01:   tb_ff <= 1'b0;
            2'b10:   tb_ff <= 1'b1;
            2'b11:   tb_ff <= ~tb_ff;
            default: ;
        endcase
    end
    assign q = stub ? 1'b0 : tb_ff;

    logic [5:0] obs      [MAXC];
    logic       obs_expq [MAXC];
    logic       obs_q    [MAXC];
    always @(negedge clk) begin
        if (cyc < MAXC) begin
            obs[cyc]      <= {j, k, done, busy, cmd_bus.cmd_ready, err};
            obs_expq[cyc] <= exp_q;
            obs_q[cyc]    <= q;
        end
    end

    // Transaction-level expectation: each accepted command owns a timeline slot
    typedef struct { int acc; int start; int fin; } sched_t;
    sched_t   sq[$];
    bit [1:0] e_jk   [MAXC];
    bit       e_done [MAXC];
    bit       e_qk   [MAXC];
    bit       e_qv   [MAXC];
    bit       mv, known;
    int       err_from = BIG;
    int       last_end = 0;
    int       tests = 0;
    int       fails = 0;

    function automatic void schedule(bit [1:0] op, int len, int acc);
        int n, st, fin;
        n   = (len == 0) ? 1 : len;
        st  = (acc + 1 > last_end + 1) ? acc + 1 : last_end + 1;
        fin = st + n + 1;
        for (int c = st + 1; c <= st + n && c < MAXC; c++) e_jk[c] = op;
        e_done[fin] = 1'b1;
        case (op)
            2'b01: begin mv = 1'b0; known = 1'b1; end
            2'b10: begin mv = 1'b1; known = 1'b1; end
            2'b11: if (n % 2 == 1) mv = ~mv;
            default: ;
        endcase
        e_qk[fin] = known;
        e_qv[fin] = mv;
        if (stub && known && mv && (fin + 1 < err_from)) err_from = fin + 1;
        sq.push_back('{acc, st, fin});
        last_end = fin;
    endfunction

    function automatic bit [5:0] exp_vec(int c);
        int  inq;
        bit  bz;
        inq = 0;
        bz  = 1'b0;
        foreach (sq[i]) begin
            if (sq[i].acc < c)   inq++;
            if (sq[i].start < c) inq--;
            if (sq[i].acc < c && c <= sq[i].fin) bz = 1'b1;
        end
        return {e_jk[c], e_done[c], bz, (inq < DEPTH), (c >= err_from)};
    endfunction

    task automatic do_reset(input int n);
        int r;
        r   = cyc;
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        for (int c = r + 1; c < r + 1500 && c < MAXC; c++) begin
            e_jk[c] = 2'b00; e_done[c] = 1'b0; e_qk[c] = 1'b0; e_qv[c] = 1'b0;
        end
        sq.delete();
        mv       = 1'b0;
        known    = 1'b0;
        err_from = BIG;
        last_end = r + n - 1;
    endtask

    task automatic push_cmd(input bit [1:0] op, input int len, output int acc);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = op;
        cmd_bus.cmd_len   = LEN_W'(len);
        acc = -1;
        for (int g = 0; g < 2000 && acc < 0; g++) begin
            @(negedge clk);
            if (cmd_bus.cmd_ready === 1'b1) acc = cyc;
            @(posedge clk);
            #1;
        end
        cmd_bus.cmd_valid = 1'b0;
        if (acc < 0) begin
            tests++; fails++;
            $display("FAIL push_timeout op=%0d len=%0d never accepted, required cmd_ready=1", op, len);
        end else begin
            schedule(op, len, acc);
        end
    endtask

    task automatic wait_idle(input int extra);
        int g;
        g = 0;
        while (cyc <= last_end + extra && g < 5000) begin
            @(posedge clk);
            #1;
            g++;
        end
    endtask

    task automatic test_reset();
        int w0;
        do_reset(2);
        w0 = cyc - 1;
        repeat (4) begin @(posedge clk); #1; end
        for (int c = w0; c < cyc; c++) begin
            tests++;
            if (obs[c] !== exp_vec(c)) begin
                fails++;
                $display("FAIL reset_idle cyc=%0d {j,k,done,busy,rdy,err} got %b required %b", c, obs[c], exp_vec(c));
            end
        end
        tests++;
        if (obs_expq[cyc - 1] !== 1'b0) begin
            fails++;
            $display("FAIL reset_exp_q got %b required 0", obs_expq[cyc - 1]);
        end
    endtask

    task automatic test_set_toggle();
        int w0, a;
        do_reset(1);
        stub = 1'b0;
        w0 = cyc;
        push_cmd(2'b10, 2, a);
        push_cmd(2'b11, 3, a);
        wait_idle(3);
        for (int c = w0; c < cyc; c++) begin
            tests++;
            if (obs[c] !== exp_vec(c)) begin
                fails++;
                $display("FAIL set_toggle cyc=%0d {j,k,done,busy,rdy,err} got %b required %b", c, obs[c], exp_vec(c));
            end
            if (e_done[c] && e_qk[c]) begin
                tests++;
                if (obs_expq[c] !== e_qv[c] || obs_q[c] !== e_qv[c]) begin
                    fails++;
                    $display("FAIL set_toggle_q cyc=%0d exp_q=%b q=%b required %b", c, obs_expq[c], obs_q[c], e_qv[c]);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        int w0, a;
        do_reset(1);
        stub = 1'b0;
        w0 = cyc;
        for (int i = 0; i < 6; i++) push_cmd(2'($urandom_range(0, 3)), 10, a);
        tests++;
        if (sq.size() == 6 && sq[5].acc !== sq[1].start + 1) begin
            fails++;
            $display("FAIL fifo_full_accept accepted at cyc %0d required %0d", sq[5].acc, sq[1].start + 1);
        end
        wait_idle(3);
        for (int c = w0; c < cyc; c++) begin
            tests++;
            if (obs[c] !== exp_vec(c)) begin
                fails++;
                $display("FAIL fifo_full cyc=%0d {j,k,done,busy,rdy,err} got %b required %b", c, obs[c], exp_vec(c));
            end
            if (e_done[c] && e_qk[c]) begin
                tests++;
                if (obs_expq[c] !== e_qv[c] || obs_q[c] !== e_qv[c]) begin
                    fails++;
                    $display("FAIL fifo_full_q cyc=%0d exp_q=%b q=%b required %b", c, obs_expq[c], obs_q[c], e_qv[c]);
                end
            end
        end
    endtask

    task automatic test_len_zero();
        int w0, a;
        do_reset(1);
        stub = 1'b1;
        w0 = cyc;
        push_cmd(2'b11, 0, a);
        wait_idle(1);
        push_cmd(2'b01, 0, a);
        wait_idle(3);
        for (int c = w0; c < cyc; c++) begin
            tests++;
            if (obs[c] !== exp_vec(c)) begin
                fails++;
                $display("FAIL len_zero cyc=%0d {j,k,done,busy,rdy,err} got %b required %b", c, obs[c], exp_vec(c));
            end
            if (e_done[c] && e_qk[c]) begin
                tests++;
                if (obs_expq[c] !== e_qv[c]) begin
                    fails++;
                    $display("FAIL len_zero_exp_q cyc=%0d got %b required %b", c, obs_expq[c], e_qv[c]);
                end
            end
        end
        stub = 1'b0;
    endtask

    task automatic test_mismatch();
        int w0, a;
        do_reset(1);
        stub = 1'b1;
        w0 = cyc;
        push_cmd(2'b10, 1, a);
        push_cmd(2'b00, $urandom_range(1, 4), a);
        wait_idle(3);
        for (int c = w0; c < cyc; c++) begin
            tests++;
            if (obs[c] !== exp_vec(c)) begin
                fails++;
                $display("FAIL mismatch cyc=%0d {j,k,done,busy,rdy,err} got %b required %b", c, obs[c], exp_vec(c));
            end
            if (e_done[c] && e_qk[c]) begin
                tests++;
                if (obs_expq[c] !== e_qv[c]) begin
                    fails++;
                    $display("FAIL mismatch_exp_q cyc=%0d got %b required %b", c, obs_expq[c], e_qv[c]);
                end
            end
        end
        stub = 1'b0;
    endtask

    task automatic test_reset_mid_drive();
        int w0, w1, a, r, g;
        do_reset(1);
        stub = 1'b0;
        w0 = cyc;
        push_cmd(2'b10, 8, a);
        push_cmd(2'b01, 8, a);
        r = sq[0].start + 3;
        g = 0;
        while (cyc < r && g < 100) begin @(posedge clk); #1; g++; end
        @(negedge clk);
        #1;
        for (int c = w0; c <= r; c++) begin
            tests++;
            if (obs[c] !== exp_vec(c)) begin
                fails++;
                $display("FAIL mid_drive_pre cyc=%0d {j,k,done,busy,rdy,err} got %b required %b", c, obs[c], exp_vec(c));
            end
        end
        do_reset(1);
        stub = 1'b1;
        w1 = cyc;
        repeat (12) begin @(posedge clk); #1; end
        tests++;
        if (obs_expq[w1] !== 1'b0) begin
            fails++;
            $display("FAIL mid_drive_exp_q got %b required 0", obs_expq[w1]);
        end
        push_cmd(2'b11, 1, a);
        wait_idle(3);
        for (int c = w1; c < cyc; c++) begin
            tests++;
            if (obs[c] !== exp_vec(c)) begin
                fails++;
                $display("FAIL mid_drive_post cyc=%0d {j,k,done,busy,rdy,err} got %b required %b", c, obs[c], exp_vec(c));
            end
        end
        stub = 1'b0;
    endtask

    task automatic test_max_len();
        int w0, a;
        do_reset(1);
        stub = 1'b0;
        w0 = cyc;
        push_cmd(2'b01, 1, a);
        push_cmd(2'b11, (1 << LEN_W) - 1, a);
        push_cmd(2'b00, 0, a);
        wait_idle(3);
        for (int c = w0; c < cyc; c++) begin
            tests++;
            if (obs[c] !== exp_vec(c)) begin
                fails++;
                $display("FAIL max_len cyc=%0d {j,k,done,busy,rdy,err} got %b required %b", c, obs[c], exp_vec(c));
            end
            if (e_done[c] && e_qk[c]) begin
                tests++;
                if (obs_expq[c] !== e_qv[c] || obs_q[c] !== e_qv[c]) begin
                    fails++;
                    $display("FAIL max_len_q cyc=%0d exp_q=%b q=%b required %b", c, obs_expq[c], obs_q[c], e_qv[c]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int w0, a;
        do_reset(1);
        stub = 1'($urandom_range(0, 1));
        w0 = cyc;
        for (int i = 0; i < 20; i++) begin
            push_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 5), a);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        wait_idle(3);
        for (int c = w0; c < cyc; c++) begin
            tests++;
            if (obs[c] !== exp_vec(c)) begin
                fails++;
                $display("FAIL back_to_back cyc=%0d {j,k,done,busy,rdy,err} got %b required %b", c, obs[c], exp_vec(c));
            end
            if (e_done[c] && e_qk[c]) begin
                tests++;
                if (obs_expq[c] !== e_qv[c]) begin
                    fails++;
                    $display("FAIL back_to_back_exp_q cyc=%0d got %b required %b", c, obs_expq[c], e_qv[c]);
                end
            end
        end
        stub = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        rst               = 1'b1;
        stub              = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        cmd_bus.cmd_op    = 2'b00;
        cmd_bus.cmd_len   = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_set_toggle();
        test_fifo_full();
        test_len_zero();
        test_mismatch();
        test_reset_mid_drive();
        test_max_len();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/jk_cmd_seq.md
Name: jk_cmd_seq

Overview:
- Command sequencer that sits directly upstream of the jkff stage and drives its j/k inputs.
- Accepts queued drive commands (hold/reset/set/toggle, each with a cycle count) over a valid/ready handshake.
- Plays each command onto j/k for the requested number of clocks.
- Keeps a reference model of the flip-flop and checks the jkff q output after every command, flagging mismatches.

Parameters:
- DEPTH, 4, command FIFO entries; power of 2, minimum 2.
- LEN_W, 8, width of the per-command cycle count.

Ports:
- clk  input  1  rising-edge clock, same clock as jkff.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command (= !full).
- cmd_op  input  2  00 hold (j=0,k=0), 01 reset (j=0,k=1), 10 set (j=1,k=0), 11 toggle (j=1,k=1).
- cmd_len  input  LEN_W  drive cycles; 0 is treated as 1.
- q  input  1  jkff output.
- j  output  1  to jkff j, registered.
- k  output  1  to jkff k, registered.
- exp_q  output  1  model's expected q.
- busy  output  1  FSM not IDLE, or FIFO not empty.
- done  output  1  one-cycle pulse in CHECK.
- err  output  1  sticky mismatch flag.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst sampled high at a clk edge):
  - FIFO flushed (count=0); state IDLE.
  - j=k=0, exp_q=0, exp_known=0, done=0, err=0.
  - Applies mid-command too: j/k drop to 0 on the next edge and the command in flight is discarded.
- FIFO push: on cmd_valid && cmd_ready, {cmd_op, cmd_len} are written.
  - When full, cmd_ready=0, even if a pop happens in the same cycle.
  - Push and pop in the same cycle are allowed when not full; count is unchanged.
  - No fall-through: a command pushed into an empty FIFO is popped at the earliest one cycle later.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE:
  - j=k=0.
  - If FIFO is non-empty: pop, latch op, set cnt = (len==0 ? 1 : len), go to DRIVE.
- DRIVE:
  - j/k are set per the latched op for exactly cnt cycles; the jkff samples them at the edge ending each cycle.
  - At each of those edges the model updates: hold leaves exp_q; reset gives 0; set gives 1; toggle gives ~exp_q.
  - Set or reset sets exp_known=1.
  - cnt decrements each cycle; on the edge where cnt==1, go to CHECK.
- CHECK (1 cycle):
  - j=k=0; done=1.
  - If exp_known and q != exp_q, err is set.
  - Next state is IDLE.
- Per-command timing: IDLE(pop) + N DRIVE cycles + 1 CHECK = N+2 cycles; back-to-back commands have no extra gap.
- Before the first set or reset after rst, exp_known=0, so hold/toggle commands skip the compare (q is unknown).
- exp_q reflects the model value, valid when exp_known=1.
- err stays set until rst; done does not depend on err.
- cnt is LEN_W bits: cmd_len = 2^LEN_W-1 gives 255 drive cycles at default, with no wrap.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, no commands.
  - Required: j=k=0, busy=0, done=0, err=0, cmd_ready=1 on every cycle.
- Set then toggle, correct jkff attached:
  - Stimulus: push (10, len 2), then (11, len 3).
  - Required: j=1,k=0 for exactly 2 cycles; done pulse with exp_q=1, q=1.
  - Required: then j=k=1 for 3 cycles; done with exp_q=0, q=0; err stays 0; total 4+5 cycles.
- FIFO full:
  - Stimulus: push 4 commands of len 10 while the FSM is busy.
  - Required: cmd_ready=0 after the 4th accept, until the first pop.
  - Required: a 5th command held valid is accepted the cycle after the pop; all 5 commands play in order.
- len=0 and hold before sync:
  - Stimulus: after rst, push (11, len 0).
  - Required: 1 drive cycle with j=k=1; done with err=0 (exp_known=0).
  - Stimulus: then push (01, len 0).
  - Required: 1 cycle k=1; exp_q=0 checked.
- Mismatch:
  - Stimulus: replace the jkff with a stub q=0; push (10, len 1).
  - Required: done with exp_q=1, q=0, err=1; err still 1 after a further hold command.
- Reset mid-DRIVE:
  - Stimulus: push (10, len 8) and (01, len 8); assert rst during the 3rd drive cycle.
  - Required: next cycle j=k=0, busy=0, FIFO empty, exp_known=0, no done pulse; the queued reset command is never played.
